// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Sequencing FSM for the multicycle RV32I core. A single memory and a single
// ALU are shared across the cycles of each instruction. This block decodes
// the fields latched in the instruction register and drives every datapath
// enable and mux select, one state per cycle.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; forces state Fetch
//   op          Instr[6:0]
//   funct3      Instr[14:12]
//   funct7b5    Instr[30]
//   Zero        ALU zero flag (used only in the branch state)
//   PCWrite     PC register enable
//   AdrSrc      memory address select: 0=PC, 1=Result
//   MemWrite    memory write strobe
//   IRWrite     instruction register / OldPC enable
//   RegWrite    register file write enable
//   ResultSrc   00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     00=PC, 01=OldPC, 10=RD1
//   ALUSrcB     00=RD2, 01=ImmExt, 10=constant 4
//   ImmSrc      00=I, 01=S, 10=B, 11=J
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   Retire      high in the final cycle of each instruction
//   dbg_state   current FSM state, for observation only
//
// Build option
//   MC_BNE_EN   when defined, bne (branch opcode, funct3=001) shares the
//               branch state with beq and the taken condition becomes
//               Zero ^ funct3[0]. When undefined, any branch-opcode
//               instruction other than beq is treated as illegal.
//
// Handshake: none. The controller free-runs; op/funct3/funct7b5 must be
// stable from Decode onward, which holds because IR is written only in Fetch.
//
// The state register is the only storage. All outputs are decoded from the
// state; PCWrite also depends on Zero, ALUControl/ImmSrc on op/funct, and
// Retire in Decode on whether the opcode is illegal.

module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Retire,
  output logic [3:0] dbg_state
);

  // ---------------------------------------------------------------------------
  // Opcodes
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ---------------------------------------------------------------------------
  // State and ALU operation encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_JAL     = 4'd8,
    S_ALUWB   = 4'd9,
    S_BEQ     = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_jal;
  logic is_branch;
  logic is_illegal;

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_jal = (op == OP_JAL);

`ifdef MC_BNE_EN
  // beq and bne share the branch state; funct3[0] flips the condition.
  assign is_branch = (op == OP_BR) && ((funct3 == 3'b000) || (funct3 == 3'b001));
`else
  assign is_branch = (op == OP_BR) && (funct3 == 3'b000);
`endif

  assign is_illegal = ~(is_lw | is_sw | is_r | is_i | is_jal | is_branch);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)   state_next = S_MEMADR;
        else if (is_r)        state_next = S_EXECR;
        else if (is_i)        state_next = S_EXECI;
        else if (is_jal)      state_next = S_JAL;
        else if (is_branch)   state_next = S_BEQ;
        else                  state_next = S_FETCH;  // illegal: retire, no writes
      end
      S_MEMADR:  state_next = is_lw ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = S_FETCH;
      S_EXECR:   state_next = S_ALUWB;
      S_EXECI:   state_next = S_ALUWB;
      S_JAL:     state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BEQ:     state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Per-state control decode (before reset gating)
  // ---------------------------------------------------------------------------
  logic   pc_update;
  logic   branch;
  logic   adr_src_raw;
  logic   mem_write_raw;
  logic   ir_write_raw;
  logic   reg_write_raw;
  logic   retire_raw;
  logic   [1:0] result_src_raw;
  logic   [1:0] alu_src_a_raw;
  logic   [1:0] alu_src_b_raw;
  aluop_t alu_op;

  always_comb begin
    pc_update      = 1'b0;
    branch         = 1'b0;
    adr_src_raw    = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    retire_raw     = 1'b0;
    result_src_raw = 2'b00;
    alu_src_a_raw  = 2'b00;
    alu_src_b_raw  = 2'b00;
    alu_op         = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_raw   = 1'b1;
        alu_src_b_raw  = 2'b10;       // PC + 4
        result_src_raw = 2'b10;       // ALUResult straight into PC
        pc_update      = 1'b1;
      end
      S_DECODE: begin
        // Branch target OldPC + imm is computed speculatively into ALUOut.
        alu_src_a_raw = 2'b01;
        alu_src_b_raw = 2'b01;
        retire_raw    = is_illegal;
      end
      S_MEMADR: begin
        alu_src_a_raw = 2'b10;
        alu_src_b_raw = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_raw = 1'b1;
      end
      S_MEMWB: begin
        result_src_raw = 2'b01;
        reg_write_raw  = 1'b1;
        retire_raw     = 1'b1;
      end
      S_MEMWR: begin
        adr_src_raw   = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_raw = 2'b10;
        alu_op        = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_raw = 2'b10;
        alu_src_b_raw = 2'b01;
        alu_op        = ALUOP_FUNCT;
      end
      S_JAL: begin
        // Link value OldPC + 4 is formed while the jump target in ALUOut
        // is loaded into the PC.
        alu_src_a_raw = 2'b01;
        alu_src_b_raw = 2'b10;
        pc_update     = 1'b1;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_raw = 2'b10;
        alu_op        = ALUOP_SUB;
        branch        = 1'b1;
        retire_raw    = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch condition
  // ---------------------------------------------------------------------------
  logic taken;
`ifdef MC_BNE_EN
  assign taken = Zero ^ funct3[0];
`else
  assign taken = Zero;
`endif

  // ---------------------------------------------------------------------------
  // Output gating: while reset is high the state already reads Fetch, so the
  // selects show Fetch values, but every enable/strobe is held low.
  // ---------------------------------------------------------------------------
  assign PCWrite   = ~reset & (pc_update | (branch & taken));
  assign IRWrite   = ~reset & ir_write_raw;
  assign MemWrite  = ~reset & mem_write_raw;
  assign RegWrite  = ~reset & reg_write_raw;
  assign Retire    = ~reset & retire_raw;
  assign AdrSrc    = adr_src_raw;
  assign ResultSrc = result_src_raw;
  assign ALUSrcA   = alu_src_a_raw;
  assign ALUSrcB   = alu_src_b_raw;

  // ---------------------------------------------------------------------------
  // ALU decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type; addi with imm[10]=1 must stay an add.
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format select, from the opcode in every state
  // ---------------------------------------------------------------------------
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule
